// File: rtl/rmt_pkg.sv
// Shared definitions for the packet-queue merger: PHV queue-tag location, merger states, tag helpers.
package rmt_pkg;

  localparam int PHV_QID_LSB  = 141;
  localparam int PHV_QID_W    = 4;
  localparam int C_NUM_QUEUES = 4;

  typedef enum logic [0:0] {
    MRG_IDLE = 1'b0,
    MRG_SEND = 1'b1
  } mrg_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [PHV_QID_W-1:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [PHV_QID_W-1:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/merger_tag_fifo.sv
// Synchronous first-word-fall-through FIFO holding queue tags; head is valid whenever !empty.
module merger_tag_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             axis_clk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign level     = level_r;
  assign head      = mem_r[rd_ptr_r];

  // storage array, written on accepted push
  always_ff @(posedge axis_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pkt_queue_rr_merger.sv
// Re-merges 4 round-robin packet queues into one AXI-Stream, ordered by per-packet queue tags.
// Optional MERGER_STATS_EN adds per-queue packet counters and the tag FIFO occupancy output.
module pkt_queue_rr_merger
  import rmt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int TAG_FIFO_DEPTH       = 16
) (
  input  logic                                        axis_clk,
  input  logic                                        areset,
  input  logic [PHV_QID_W-1:0]                        s_tag_queue,
  input  logic                                        s_tag_valid,
  output logic                                        s_tag_ready,
  input  logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_QUEUES-1:0]                     s_axis_tlast,
  input  logic [C_NUM_QUEUES-1:0]                     s_axis_tvalid,
  output logic [C_NUM_QUEUES-1:0]                     s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        order_err,
  output logic                                        tag_err
`ifdef MERGER_STATS_EN
  ,
  output logic [C_NUM_QUEUES*32-1:0]                  pkt_cnt,
  output logic [$clog2(TAG_FIFO_DEPTH):0]             tag_fifo_level
`endif
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int AW = $clog2(TAG_FIFO_DEPTH);

  mrg_state_e           state_r;
  logic [1:0]           sel_r;
  logic [1:0]           exp_q_r;
  logic                 order_err_r;
  logic                 tag_err_r;
  logic [PHV_QID_W-1:0] head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;
  logic                 beat_hs_s;
  logic                 last_hs_s;
`ifdef MERGER_STATS_EN
  logic [AW:0]          level_s;
`else
  logic [AW:0]          level_unused_s;
`endif

  merger_tag_fifo #(
    .WIDTH (PHV_QID_W),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .axis_clk (axis_clk),
    .areset   (areset),
    .push     (s_tag_valid),
    .din      (s_tag_queue),
    .pop      (pop_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s),
`ifdef MERGER_STATS_EN
    .level    (level_s)
`else
    .level    (level_unused_s)
`endif
  );

  assign s_tag_ready = !full_s;
  assign pop_s       = (state_r == MRG_IDLE) && !empty_s;
  assign beat_hs_s   = (state_r == MRG_SEND) && s_axis_tvalid[sel_r] && m_axis_tready;
  assign last_hs_s   = beat_hs_s && s_axis_tlast[sel_r];
  assign order_err   = order_err_r;
  assign tag_err     = tag_err_r;

  // payload follows the selected queue; the queue holds it stable under backpressure
  assign m_axis_tdata = s_axis_tdata[int'(sel_r)*DW +: DW];
  assign m_axis_tuser = s_axis_tuser[int'(sel_r)*UW +: UW];
  assign m_axis_tkeep = s_axis_tkeep[int'(sel_r)*KW +: KW];
  assign m_axis_tlast = s_axis_tlast[sel_r];

  // handshake routing: only the granted queue sees downstream ready
  always_comb begin
    s_axis_tready = {C_NUM_QUEUES{1'b0}};
    m_axis_tvalid = 1'b0;
    if (state_r == MRG_SEND) begin
      s_axis_tready[sel_r] = m_axis_tready;
      m_axis_tvalid        = s_axis_tvalid[sel_r];
    end else begin
      s_axis_tready = {C_NUM_QUEUES{1'b0}};
      m_axis_tvalid = 1'b0;
    end
  end

  // grant FSM: a one-hot tag grants one packet; expected queue resyncs to each granted tag
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_r     <= MRG_IDLE;
      sel_r       <= 2'd0;
      exp_q_r     <= 2'd0;
      order_err_r <= 1'b0;
      tag_err_r   <= 1'b0;
    end else begin
      case (state_r)
        MRG_IDLE: begin
          if (!empty_s) begin
            if (is_onehot(head_s)) begin
              sel_r   <= onehot_to_idx(head_s);
              exp_q_r <= onehot_to_idx(head_s) + 2'd1;
              state_r <= MRG_SEND;
              if (head_s != (4'b0001 << exp_q_r)) order_err_r <= 1'b1;
            end else begin
              tag_err_r <= 1'b1;
            end
          end
        end
        MRG_SEND: begin
          if (last_hs_s) state_r <= MRG_IDLE;
        end
        default: state_r <= MRG_IDLE;
      endcase
    end
  end

`ifdef MERGER_STATS_EN
  logic [31:0] pkt_cnt_r [C_NUM_QUEUES];

  // per-queue completed-packet counters, wrapping at 2^32
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      for (int i = 0; i < C_NUM_QUEUES; i++) pkt_cnt_r[i] <= 32'd0;
    end else if (last_hs_s) begin
      pkt_cnt_r[sel_r] <= pkt_cnt_r[sel_r] + 32'd1;
    end
  end

  // flatten counters onto the packed port
  always_comb begin
    pkt_cnt = {(C_NUM_QUEUES*32){1'b0}};
    for (int i = 0; i < C_NUM_QUEUES; i++) pkt_cnt[i*32 +: 32] = pkt_cnt_r[i];
  end

  assign tag_fifo_level = level_s;
`endif

endmodule

// File: tb/tb_pkt_queue_rr_merger.sv
// Self-checking bench: queue-based behavioural model compared every cycle, plus directed literal checks.
module tb_pkt_queue_rr_merger;

  localparam int DW    = 512;
  localparam int UW    = 128;
  localparam int KW    = DW / 8;
  localparam int NQ    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic              axis_clk = 1'b0;
  logic              areset = 1'b1;
  logic [3:0]        s_tag_queue = 4'b0000;
  logic              s_tag_valid = 1'b0;
  logic              s_tag_ready;
  logic [NQ*DW-1:0]  s_axis_tdata = '0;
  logic [NQ*UW-1:0]  s_axis_tuser = '0;
  logic [NQ*KW-1:0]  s_axis_tkeep = '0;
  logic [NQ-1:0]     s_axis_tlast = '0;
  logic [NQ-1:0]     s_axis_tvalid = '0;
  logic [NQ-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [UW-1:0]     m_axis_tuser;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              order_err;
  logic              tag_err;
`ifdef MERGER_STATS_EN
  logic [NQ*32-1:0]  pkt_cnt;
  logic [4:0]        tag_fifo_level;
`endif

  pkt_queue_rr_merger #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .C_NUM_QUEUES         (NQ),
    .TAG_FIFO_DEPTH       (DEPTH)
  ) dut (
    .axis_clk      (axis_clk),
    .areset        (areset),
    .s_tag_queue   (s_tag_queue),
    .s_tag_valid   (s_tag_valid),
    .s_tag_ready   (s_tag_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .order_err     (order_err),
    .tag_err       (tag_err)
`ifdef MERGER_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .tag_fifo_level (tag_fifo_level)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  // stimulus sources and behavioural model
  beat_t       src_q [NQ][$];
  bit [NQ-1:0] gate = '1;
  bit [3:0]    m_tags [$];
  int          m_cur = -1;
  int          m_exp = 0;
  bit          m_oerr = 1'b0;
  bit          m_terr = 1'b0;
  int unsigned m_cnt [NQ];
  bit          chk_on = 1'b0;
  bit          auto_pkt = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pkt_serial = 0;
  int          dut_beats = 0;
  int          dut_tag_acc = 0;
  int          first_beat_cyc = -1;
  int          last_beat_cyc = -1;
  logic [15:0] beat_log [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk_beat(input int q, input int b, input bit last);
    beat_t x;
    for (int w = 0; w < DW/32; w++) x.data[w*32 +: 32] = $urandom;
    x.data[31:0] = {pkt_serial[15:0], b[7:0], q[7:0]};
    for (int w = 0; w < UW/32; w++) x.user[w*32 +: 32] = $urandom;
    x.keep = {$urandom, $urandom};
    x.last = last;
    return x;
  endfunction

  task automatic add_pkt(input int q, input int len);
    for (int b = 0; b < len; b++) src_q[q].push_back(mk_beat(q, b, b == len - 1));
    pkt_serial++;
  endtask

  // one clock cycle: drive sources, compare at negedge, advance model at posedge
  task automatic step();
    beat_t      hb;
    bit [3:0]   t;
    int         cs;
    int         idx;
    bit         exp_ready, exp_mv, beat_hs, tag_hs;
    logic [3:0] exp_tr;
    for (int q = 0; q < NQ; q++) begin
      if (src_q[q].size() > 0) begin
        s_axis_tvalid[q]            = gate[q];
        s_axis_tdata[q*DW +: DW]    = src_q[q][0].data;
        s_axis_tuser[q*UW +: UW]    = src_q[q][0].user;
        s_axis_tkeep[q*KW +: KW]    = src_q[q][0].keep;
        s_axis_tlast[q]             = src_q[q][0].last;
      end else begin
        s_axis_tvalid[q] = 1'b0;
        s_axis_tlast[q]  = 1'b0;
      end
    end
    @(negedge axis_clk);
    exp_ready = (m_tags.size() < DEPTH);
    exp_mv    = (m_cur >= 0) && s_axis_tvalid[m_cur];
    exp_tr    = (m_cur >= 0) ? ({3'b000, m_axis_tready} << m_cur) : 4'b0000;
    if (chk_on) begin
      chk("s_tag_ready", s_tag_ready, exp_ready);
      chk("m_axis_tvalid", m_axis_tvalid, exp_mv);
      chk("s_axis_tready", s_axis_tready, exp_tr);
      chk("order_err", order_err, m_oerr);
      chk("tag_err", tag_err, m_terr);
      if (exp_mv) begin
        chk("m_axis_tdata", m_axis_tdata, src_q[m_cur][0].data);
        chk("m_axis_tuser", m_axis_tuser, src_q[m_cur][0].user);
        chk("m_axis_tkeep", m_axis_tkeep, src_q[m_cur][0].keep);
        chk("m_axis_tlast", m_axis_tlast, src_q[m_cur][0].last);
      end
`ifdef MERGER_STATS_EN
      chk("tag_fifo_level", tag_fifo_level, m_tags.size());
      for (int q = 0; q < NQ; q++) chk("pkt_cnt", pkt_cnt[q*32 +: 32], m_cnt[q]);
`endif
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      dut_beats++;
      beat_log.push_back(m_axis_tdata[15:0]);
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
    end
    if (s_tag_valid && s_tag_ready === 1'b1) dut_tag_acc++;
    beat_hs = exp_mv && m_axis_tready;
    tag_hs  = s_tag_valid && exp_ready;
    @(posedge axis_clk);
    cyc++;
    if (areset) begin
      m_tags.delete();
      m_cur  = -1;
      m_exp  = 0;
      m_oerr = 1'b0;
      m_terr = 1'b0;
      for (int q = 0; q < NQ; q++) begin
        m_cnt[q] = 0;
        src_q[q].delete();
      end
      chk_on = 1'b1;
    end else begin
      cs = m_cur;
      if (beat_hs) begin
        hb = src_q[cs].pop_front();
        if (hb.last) begin
          m_cnt[cs]++;
          m_cur = -1;
        end
      end
      if (cs < 0 && m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if ($onehot(t)) begin
          idx = $clog2(t);
          if (t != (4'b0001 << m_exp)) m_oerr = 1'b1;
          m_exp = (idx + 1) % NQ;
          m_cur = idx;
        end else begin
          m_terr = 1'b1;
        end
      end
      if (tag_hs) begin
        m_tags.push_back(s_tag_queue);
        if (auto_pkt && $onehot(s_tag_queue)) add_pkt($clog2(s_tag_queue), $urandom_range(1, 4));
      end
    end
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tag_valid = 1'b0;
    step();
    step();
    areset = 1'b0;
    dut_beats = 0;
    beat_log.delete();
    first_beat_cyc = -1;
    last_beat_cyc = -1;
  endtask

  task automatic push_tag(input logic [3:0] t);
    s_tag_queue = t;
    s_tag_valid = 1'b1;
    step();
    s_tag_valid = 1'b0;
  endtask

  bit mr_pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit gv_pat [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int c0;
    int budget;
    logic [15:0] lv;
    // reset values
    do_reset();
    chk("rst s_tag_ready", s_tag_ready, 1'b1);
    chk("rst m_axis_tvalid", m_axis_tvalid, 1'b0);
    chk("rst s_axis_tready", s_axis_tready, 4'b0000);
    chk("rst errors", {order_err, tag_err}, 2'b00);

    // four 3-beat packets in round-robin order
    for (int q = 0; q < NQ; q++) add_pkt(q, 3);
    c0 = cyc;
    s_tag_valid = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      s_tag_queue = 4'b0001 << q;
      step();
    end
    s_tag_valid = 1'b0;
    repeat (16) step();
    chk("rr beats", dut_beats, 12);
    chk("rr first beat latency", first_beat_cyc - c0, 2);
    chk("rr last beat cycle", last_beat_cyc - c0, 16);
    chk("rr order_err", order_err, 1'b0);
    for (int i = 0; i < 12 && i < beat_log.size(); i++) begin
      lv = beat_log[i];
      chk("rr beat queue", lv[7:0], i / 3);
    end

    // out-of-order tag flags order_err, then resync
    do_reset();
    add_pkt(1, 1);
    add_pkt(2, 2);
    push_tag(4'b0010);
    push_tag(4'b0100);
    repeat (8) step();
    chk("order order_err", order_err, 1'b1);
    chk("order tag_err", tag_err, 1'b0);
    chk("order beats", dut_beats, 3);

    // malformed tags are dropped
    do_reset();
    push_tag(4'b0000);
    push_tag(4'b0011);
    repeat (4) step();
    chk("tagerr tag_err", tag_err, 1'b1);
    chk("tagerr order_err", order_err, 1'b0);
    chk("tagerr beats", dut_beats, 0);
    chk("tagerr idle tready", s_axis_tready, 4'b0000);

    // FIFO full: one tag popped into SEND, 16 more fill the FIFO
    do_reset();
    dut_tag_acc = 0;
    s_tag_queue = 4'b0001;
    s_tag_valid = 1'b1;
    repeat (20) step();
    chk("full tags accepted", dut_tag_acc, 17);
    chk("full s_tag_ready", s_tag_ready, 1'b0);
    add_pkt(0, 1);
    budget = 0;
    while (dut_tag_acc < 18 && budget < 10) begin
      step();
      budget++;
    end
    s_tag_valid = 1'b0;
    chk("full 18th tag accepted", dut_tag_acc, 18);

    // backpressure and source gaps on queue 2
    do_reset();
    add_pkt(2, 4);
    push_tag(4'b0100);
    for (int i = 0; i < 12; i++) begin
      m_axis_tready = mr_pat[i];
      gate[2] = gv_pat[i];
      step();
    end
    m_axis_tready = 1'b1;
    gate = '1;
    chk("bp beats", dut_beats, 4);
    for (int i = 0; i < 4 && i < beat_log.size(); i++) begin
      lv = beat_log[i];
      chk("bp beat order", {lv[15:8], lv[7:0]}, {i[7:0], 8'd2});
    end

    // randomized traffic
    do_reset();
    auto_pkt = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 8) s_tag_queue = 4'b0001 << $urandom_range(0, 3);
      else s_tag_queue = 4'($urandom_range(0, 15));
      s_tag_valid   = ($urandom_range(0, 3) == 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      for (int q = 0; q < NQ; q++) gate[q] = ($urandom_range(0, 4) != 0);
      step();
    end
    auto_pkt = 1'b0;
    s_tag_valid = 1'b0;
    m_axis_tready = 1'b1;
    gate = '1;
    budget = 0;
    while ((m_cur >= 0 || m_tags.size() > 0) && budget < 2000) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 2000) begin
      errors++;
      $display("FAIL drain: model still busy after %0d cycles", budget);
    end

    // reset during beat 2 of a 4-beat packet
    add_pkt(0, 4);
    push_tag(4'b0001);
    step();
    step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("midrst s_axis_tready", s_axis_tready, 4'b0000);
    chk("midrst m_axis_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst errors", {order_err, tag_err}, 2'b00);
    chk("midrst s_tag_ready", s_tag_ready, 1'b1);
`ifdef MERGER_STATS_EN
    chk("midrst pkt_cnt", pkt_cnt, '0);
    chk("midrst level", tag_fifo_level, 5'd0);
`endif
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
